// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
// lz_dark() decides whether a leading-zero digit may stay unlit.
package display_pkg;

    localparam int   NUM_DIGITS = 4;
    localparam int   DIGIT_W    = 4;
    localparam logic DP_OFF     = 1'b1;

    typedef enum logic {SHOW, BLANK} scan_state_t;
    typedef logic [NUM_DIGITS*DIGIT_W-1:0] disp_value_t;
    typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

    // Digit k is a leading zero when it and every higher nibble are zero and its dp is off.
    function automatic logic lz_dark(input disp_value_t               value,
                                     input logic [NUM_DIGITS-1:0]     dp,
                                     input digit_idx_t                k);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(k) && value[i*DIGIT_W +: DIGIT_W] != '0) begin
                upper_zero = 1'b0;
            end
        end
        return (k != '0) && upper_zero && (dp[k] == DP_OFF);
    endfunction

endpackage

// File: rtl/display_load_buffer.sv
// Double buffer for the displayed value: one pending slot filled by valid/ready, copied to the
// committed outputs on i_commit. Ready is low whenever the slot is full; no bypass to the outputs.
module display_load_buffer
    import display_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_commit,
    input  logic                  i_load_vld,
    output logic                  o_load_rdy,
    input  disp_value_t           i_value,
    input  logic [NUM_DIGITS-1:0] i_dp,
    output disp_value_t           o_value,
    output logic [NUM_DIGITS-1:0] o_dp
);

    logic                  r_pend_vld;
    disp_value_t           r_pend_value;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    disp_value_t           r_value;
    logic [NUM_DIGITS-1:0] r_dp;
    logic                  w_xfer;

    assign w_xfer     = i_load_vld && !r_pend_vld;
    assign o_load_rdy = !r_pend_vld;
    assign o_value    = r_value;
    assign o_dp       = r_dp;

    // A transfer needs an empty slot, so it can never coincide with a commit of that slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_vld   <= 1'b0;
            r_pend_value <= '0;
            r_pend_dp    <= {NUM_DIGITS{DP_OFF}};
            r_value      <= '0;
            r_dp         <= {NUM_DIGITS{DP_OFF}};
        end else if (w_xfer) begin
            r_pend_vld   <= 1'b1;
            r_pend_value <= i_value;
            r_pend_dp    <= i_dp;
        end else if (i_commit && r_pend_vld) begin
            r_pend_vld   <= 1'b0;
            r_value      <= r_pend_value;
            r_dp         <= r_pend_dp;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// 4-digit seven-segment scan sequencer: SHOW/BLANK phases per digit, registered anodes, loads
// committed only at frame wrap. Optional LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    output logic [15:0] value_out,
    output logic [3:0]  dp_out,
    output logic [1:0]  digit_select,
    output logic [3:0]  anode_n,
    output logic        frame_done
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

    scan_state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    digit_idx_t             r_digit, w_digit_nxt;
    logic                   r_first, w_first_nxt;
    logic [NUM_DIGITS-1:0]  r_anode_n, w_anode_nxt;
    logic                   r_frame_done;
    logic                   w_wrap;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_digit      <= '0;
            r_first      <= 1'b1;
            r_anode_n    <= {NUM_DIGITS{1'b1}};
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_digit      <= w_digit_nxt;
            r_first      <= w_first_nxt;
            r_anode_n    <= w_anode_nxt;
            r_frame_done <= w_wrap;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_digit_nxt = r_digit;
        w_first_nxt = r_first;
        w_wrap      = 1'b0;
        if (enable) begin
            unique case (r_state)
                SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_cnt_nxt = '0;
                        if (BLANK_CYCLES == 0) begin
                            w_digit_nxt = r_digit + 2'd1;
                            w_wrap      = (r_digit == 2'd3);
                        end else begin
                            w_state_nxt = BLANK;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = SHOW;
                        w_cnt_nxt   = '0;
                        w_first_nxt = 1'b0;
                        // The blank right after reset lights digit 0 instead of advancing.
                        if (!r_first) begin
                            w_digit_nxt = r_digit + 2'd1;
                            w_wrap      = (r_digit == 2'd3);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        w_anode_nxt = {NUM_DIGITS{1'b1}};
        if (enable && w_state_nxt == SHOW) begin
            w_anode_nxt = ~(4'b0001 << w_digit_nxt);
`ifdef LEADING_ZERO_BLANK_EN
            if (lz_dark(value_out, dp_out, w_digit_nxt)) begin
                w_anode_nxt = {NUM_DIGITS{1'b1}};
            end
`endif
        end
    end

    assign digit_select = r_digit;
    assign anode_n      = r_anode_n;
    assign frame_done   = r_frame_done;

    display_load_buffer u_load_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_commit   (w_wrap),
        .i_load_vld (load_valid),
        .o_load_rdy (load_ready),
        .i_value    (value_in),
        .i_dp       (dp_in),
        .o_value    (value_out),
        .o_dp       (dp_out)
    );

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench: scan pattern scoreboard for BLANK_CYCLES=2 and 0, load/commit handshake,
// enable freeze, mid-handshake reset and leading-zero blanking (macro-dependent expectations).
module tb_display_scan_controller;

    localparam int RDIV  = 4;
    localparam int BLK   = 2;
    localparam int FRAME = 4 * (RDIV + BLK);

    typedef struct packed {
        logic [3:0] an;
        logic [1:0] dig;
        logic       fd;
    } scan_exp_t;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
    } load_exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load_valid;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load_ready;
    logic [15:0] value_out;
    logic [3:0]  dp_out;
    logic [1:0]  digit_select;
    logic [3:0]  anode_n;
    logic        frame_done;

    logic        nb_enable     = 1'b1;
    logic        nb_load_valid = 1'b0;
    logic [15:0] nb_value_in   = 16'h0000;
    logic [3:0]  nb_dp_in      = 4'hF;
    logic        nb_load_ready;
    logic [15:0] nb_value_out;
    logic [3:0]  nb_dp_out;
    logic [1:0]  nb_digit_select;
    logic [3:0]  nb_anode_n;
    logic        nb_frame_done;

    scan_exp_t q_scan[$];
    scan_exp_t q_scan_nb[$];
    load_exp_t q_load[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    int        cyc;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    display_scan_controller #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLK)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .value_in     (value_in),
        .dp_in        (dp_in),
        .value_out    (value_out),
        .dp_out       (dp_out),
        .digit_select (digit_select),
        .anode_n      (anode_n),
        .frame_done   (frame_done)
    );

    display_scan_controller #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(0)) dut_nb (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (nb_enable),
        .load_valid   (nb_load_valid),
        .load_ready   (nb_load_ready),
        .value_in     (nb_value_in),
        .dp_in        (nb_dp_in),
        .value_out    (nb_value_out),
        .dp_out       (nb_dp_out),
        .digit_select (nb_digit_select),
        .anode_n      (nb_anode_n),
        .frame_done   (nb_frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_scan(input bit nb, input logic [3:0] an, input int d, input logic fd);
        scan_exp_t e;
        e.an  = an;
        e.dig = 2'(d);
        e.fd  = fd;
        if (nb) q_scan_nb.push_back(e);
        else    q_scan.push_back(e);
    endtask

    // Expected per-cycle pattern from release: initial blank on digit 0, then SHOW/BLANK per digit.
    task automatic build_scan(input bit nb, input int rdiv, input int blank, input int frames);
        int init;
        init = (blank == 0) ? 1 : blank;
        for (int i = 0; i < init; i++) push_scan(nb, 4'hF, 0, 1'b0);
        for (int f = 0; f < frames; f++) begin
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < rdiv; c++)
                    push_scan(nb, ~(4'b0001 << d), d, (f > 0 && d == 0 && c == 0));
                for (int c = 0; c < blank; c++)
                    push_scan(nb, 4'hF, d, 1'b0);
            end
        end
    endtask

    task automatic push_load(input logic [15:0] v, input logic [3:0] d);
        load_exp_t le;
        le.val = v;
        le.dp  = d;
        q_load.push_back(le);
    endtask

    task automatic pop_load_chk(input string tag);
        load_exp_t le;
        chk({tag, "_qnonempty"}, q_load.size() > 0, 1'b1);
        if (q_load.size() > 0) begin
            le = q_load.pop_front();
            chk({tag, "_val"}, value_out, le.val);
            chk({tag, "_dp"}, dp_out, le.dp);
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b1;
        #1;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        enable     = 1'b1;
        value_in   = 16'h0000;
        dp_in      = 4'hF;
        repeat (2) @(negedge clk);
        chk("rst_anode", anode_n, 4'hF);
        chk("rst_digit", digit_select, 2'd0);
        chk("rst_value", value_out, 16'h0000);
        chk("rst_dp", dp_out, 4'hF);
        chk("rst_ready", load_ready, 1'b1);
        chk("rst_fd", frame_done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_fd(input string tag);
        @(negedge clk);
        for (int i = 0; i < 200 && frame_done !== 1'b1; i++) @(negedge clk);
        chk(tag, frame_done, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        scan_exp_t e;
        int hold;
        int ce, cd, cb, c7, cf;

        // Scan pattern for both blanking configurations, two frames from release.
        do_reset();
        build_scan(1'b0, RDIV, BLK, 2);
        build_scan(1'b1, RDIV, 0, 2);
        for (int i = 0; i < 2 + 2 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (q_scan.size() > 0) begin
                e = q_scan.pop_front();
                chk("scan_anode", anode_n, e.an);
                chk("scan_digit", digit_select, e.dig);
                chk("scan_fd", frame_done, e.fd);
            end
            if (q_scan_nb.size() > 0) begin
                e = q_scan_nb.pop_front();
                chk("noblank_anode", nb_anode_n, e.an);
                chk("noblank_digit", nb_digit_select, e.dig);
                chk("noblank_fd", nb_frame_done, e.fd);
            end
        end

        // Single load mid-frame, committed at the first wrap (cycle 26 after release).
        do_reset();
        repeat (10) @(negedge clk);
        chk("ld_ready_pre", load_ready, 1'b1);
        load_valid = 1'b1;
        value_in   = 16'h1234;
        dp_in      = 4'hB;
        @(negedge clk);
        push_load(16'h1234, 4'hB);
        load_valid = 1'b0;
        value_in   = 16'hDEAD;
        dp_in      = 4'h0;
        chk("ld_ready_drop", load_ready, 1'b0);
        chk("ld_hold_early", value_out, 16'h0000);
        while (cyc < 25) @(negedge clk);
        chk("ld_hold_late", value_out, 16'h0000);
        wait_fd("ld_fd_seen");
        chk("ld_fd_cycle", cyc, 26);
        pop_load_chk("ld_commit");
        chk("ld_ready_back", load_ready, 1'b1);

        // Back-to-back: A accepted now, B held off until the wrap commits A.
        load_valid = 1'b1;
        value_in   = 16'h5678;
        dp_in      = 4'h7;
        @(negedge clk);
        push_load(16'h5678, 4'h7);
        chk("b2b_a_ready", load_ready, 1'b0);
        value_in = 16'h9ABC;
        dp_in    = 4'hE;
        hold = 0;
        while (load_ready !== 1'b1 && hold < 200) begin
            hold++;
            @(negedge clk);
        end
        chk("b2b_hold_cycles", hold, FRAME - 1);
        chk("b2b_wrap_fd", frame_done, 1'b1);
        pop_load_chk("b2b_commit_a");
        @(negedge clk);
        push_load(16'h9ABC, 4'hE);
        load_valid = 1'b0;
        chk("b2b_b_ready", load_ready, 1'b0);
        chk("b2b_b_not_yet", value_out, 16'h5678);
        wait_fd("b2b_fd2_seen");
        pop_load_chk("b2b_commit_b");

        // Transfer on the wrap edge itself goes to the slot, not the outputs.
        repeat (FRAME - 1) @(negedge clk);
        chk("nobyp_ready_pre", load_ready, 1'b1);
        load_valid = 1'b1;
        value_in   = 16'h0F0F;
        dp_in      = 4'hD;
        @(negedge clk);
        load_valid = 1'b0;
        chk("nobyp_fd", frame_done, 1'b1);
        chk("nobyp_value", value_out, 16'h9ABC);
        chk("nobyp_ready", load_ready, 1'b0);
        push_load(16'h0F0F, 4'hD);
        wait_fd("nobyp_fd2_seen");
        pop_load_chk("nobyp_commit");

        // Reset with a load pending discards it.
        load_valid = 1'b1;
        value_in   = 16'h1111;
        dp_in      = 4'h1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("mr_ready_full", load_ready, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mr_value", value_out, 16'h0000);
        chk("mr_dp", dp_out, 4'hF);
        chk("mr_ready", load_ready, 1'b1);
        chk("mr_anode", anode_n, 4'hF);
        chk("mr_digit", digit_select, 2'd0);
        chk("mr_fd", frame_done, 1'b0);
        q_load.delete();
        @(negedge clk);
        reset_n = 1'b1;
        wait_fd("mr_fd_seen");
        chk("mr_discarded", value_out, 16'h0000);
        chk("mr_fd_cycle", cyc, 26);

        // Enable dropped for 10 cycles after two lit cycles of digit 2; a load is taken meanwhile.
        for (int i = 0; i < 100 && anode_n !== 4'hB; i++) @(negedge clk);
        chk("en_reach_d2", anode_n, 4'hB);
        @(negedge clk);
        enable     = 1'b0;
        load_valid = 1'b1;
        value_in   = 16'h0042;
        dp_in      = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                load_valid = 1'b0;
                push_load(16'h0042, 4'hF);
                chk("en_off_load_taken", load_ready, 1'b0);
            end
            chk("en_off_anode", anode_n, 4'hF);
            chk("en_off_digit", digit_select, 2'd2);
            chk("en_off_fd", frame_done, 1'b0);
        end
        enable = 1'b1;
        @(negedge clk);
        chk("en_resume1", anode_n, 4'hB);
        @(negedge clk);
        chk("en_resume2", anode_n, 4'hB);
        @(negedge clk);
        chk("en_blank_after", anode_n, 4'hF);
        chk("en_blank_digit", digit_select, 2'd2);
        repeat (2) @(negedge clk);
        chk("en_next_anode", anode_n, 4'h7);
        chk("en_next_digit", digit_select, 2'd3);

        // Leading-zero blanking over one full frame with 0042 / dp F committed.
        wait_fd("lz_fd_seen");
        pop_load_chk("lz_commit");
        ce = 0; cd = 0; cb = 0; c7 = 0; cf = 0;
        for (int i = 0; i < FRAME; i++) begin
            case (anode_n)
                4'hE:    ce++;
                4'hD:    cd++;
                4'hB:    cb++;
                4'h7:    c7++;
                4'hF:    cf++;
                default: ;
            endcase
            @(negedge clk);
        end
        chk("lz_digit0_lit", ce, RDIV);
        chk("lz_digit1_lit", cd, RDIV);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_digit2_dark", cb, 0);
        chk("lz_digit3_dark", c7, 0);
        chk("lz_dark_cycles", cf, 4 * BLK + 2 * RDIV);
`else
        chk("lz_digit2_lit", cb, RDIV);
        chk("lz_digit3_lit", c7, RDIV);
        chk("lz_dark_cycles", cf, 4 * BLK);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
